// File: rtl/prim_pkg.sv
// Shared encodings and FIFO entry record for the primitive assembler.
// The entry record is sized by PRIM_VTX_W; prim_assembler's VTX_WIDTH must match it.
package prim_pkg;

    localparam int PRIM_VTX_W = 32;

    // PrimitiveType input codes
    localparam logic [3:0] PT_POINTS     = 4'd0;
    localparam logic [3:0] PT_LINES      = 4'd1;
    localparam logic [3:0] PT_TRIANGLES  = 4'd2;
    localparam logic [3:0] PT_LINE_STRIP = 4'd3;
    localparam logic [3:0] PT_TRI_STRIP  = 4'd4;

    // Prim_Type output codes
    localparam logic [1:0] OT_POINT = 2'd0;
    localparam logic [1:0] OT_LINE  = 2'd1;
    localparam logic [1:0] OT_TRI   = 2'd2;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_ASSEMBLE = 1'b1;

    typedef struct packed {
        logic [1:0]            ptype;
        logic [PRIM_VTX_W-1:0] v0;
        logic [PRIM_VTX_W-1:0] v1;
        logic [PRIM_VTX_W-1:0] v2;
    } prim_entry_t;

    function automatic logic type_valid(input logic [3:0] t);
        return (t <= PT_TRI_STRIP);
    endfunction

endpackage

// File: rtl/prim_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; async active-high reset.
// A push while full is accepted only when a pop happens in the same cycle.
module prim_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/prim_assembler.sv
// Groups decoded vertices into points/lines/triangles and queues them for the rasterizer.
// Optional macro PRIM_STRIP_WINDING_EN: swap V0/V1 on every 2nd, 4th, ... triangle-strip triangle.
module prim_assembler
    import prim_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int VTX_WIDTH  = PRIM_VTX_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [VTX_WIDTH-1:0] Vertex,
    input  logic                 VertexValid,
    input  logic                 StartPrimitive,
    input  logic [3:0]           PrimitiveType,
    input  logic                 EndPrimitive,
    input  logic                 Draw,
    output logic                 Stall,
    output logic                 Prim_Valid,
    input  logic                 Prim_Ready,
    output logic [1:0]           Prim_Type,
    output logic [VTX_WIDTH-1:0] Prim_V0,
    output logic [VTX_WIDTH-1:0] Prim_V1,
    output logic [VTX_WIDTH-1:0] Prim_V2,
    output logic                 Frame_Done,
    output logic                 Err,
    output logic                 Overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [0:0]           state_q, state_d;
    logic [3:0]           ptype_q, ptype_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [VTX_WIDTH-1:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
    logic                 draw_pend_q, draw_pend_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
`ifdef PRIM_STRIP_WINDING_EN
    logic                 odd_q, odd_d;
`endif

    prim_entry_t   ent, head;
    logic          push, pop, empty, full, frame_done;
    logic [CW-1:0] occ;

    always_comb begin
        state_d = state_q;
        ptype_d = ptype_q;
        cnt_d   = cnt_q;
        h0_d    = h0_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
        err_d   = err_q;
        push    = 1'b0;
        ent     = '0;
`ifdef PRIM_STRIP_WINDING_EN
        odd_d   = odd_q;
`endif
        // StartPrimitive wins over any vertex in the same cycle.
        if (StartPrimitive) begin
            if (state_q == ST_ASSEMBLE) err_d = 1'b1;
            if (type_valid(PrimitiveType)) begin
                state_d = ST_ASSEMBLE;
                ptype_d = PrimitiveType;
                cnt_d   = '0;
                h0_d    = '0;
                h1_d    = '0;
                h2_d    = '0;
`ifdef PRIM_STRIP_WINDING_EN
                odd_d   = 1'b0;
`endif
            end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_IDLE) begin
            if (VertexValid || EndPrimitive) err_d = 1'b1;
        end else begin
            if (VertexValid) begin
                h0_d  = h1_q;
                h1_d  = h2_q;
                h2_d  = Vertex;
                cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                // cnt_q counts vertices already held, before this one.
                case (ptype_q)
                    PT_POINTS: begin
                        push = 1'b1;
                        ent  = '{ptype: OT_POINT, v0: h2_d, v1: '0, v2: '0};
                    end
                    PT_LINES: if (cnt_q == 2'd1) begin
                        push  = 1'b1;
                        cnt_d = '0;
                        ent   = '{ptype: OT_LINE, v0: h1_d, v1: h2_d, v2: '0};
                    end
                    PT_TRIANGLES: if (cnt_q == 2'd2) begin
                        push  = 1'b1;
                        cnt_d = '0;
                        ent   = '{ptype: OT_TRI, v0: h0_d, v1: h1_d, v2: h2_d};
                    end
                    PT_LINE_STRIP: if (cnt_q >= 2'd1) begin
                        push = 1'b1;
                        ent  = '{ptype: OT_LINE, v0: h1_d, v1: h2_d, v2: '0};
                    end
                    PT_TRI_STRIP: if (cnt_q >= 2'd2) begin
                        push = 1'b1;
                        ent  = '{ptype: OT_TRI, v0: h0_d, v1: h1_d, v2: h2_d};
`ifdef PRIM_STRIP_WINDING_EN
                        odd_d = ~odd_q;
                        if (odd_q) begin
                            ent.v0 = h1_d;
                            ent.v1 = h0_d;
                        end
`endif
                    end
                    default: ;
                endcase
            end
            if (EndPrimitive) state_d = ST_IDLE;
        end
    end

    assign frame_done  = draw_pend_q & (state_q == ST_IDLE) & empty;
    assign draw_pend_d = frame_done ? 1'b0 : (draw_pend_q | Draw);
    assign ovf_d       = ovf_q | (push & full & ~pop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            ptype_q     <= '0;
            cnt_q       <= '0;
            h0_q        <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            draw_pend_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef PRIM_STRIP_WINDING_EN
            odd_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptype_q     <= ptype_d;
            cnt_q       <= cnt_d;
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            draw_pend_q <= draw_pend_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
`ifdef PRIM_STRIP_WINDING_EN
            odd_q       <= odd_d;
`endif
        end
    end

    assign pop = ~empty & Prim_Ready;

    prim_fifo #(
        .WIDTH($bits(prim_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst  (RESET),
        .push (push),
        .wdata(ent),
        .pop  (pop),
        .rdata(head),
        .count(occ),
        .empty(empty),
        .full (full)
    );

    // Head fields are gated so an empty FIFO shows all zeros.
    assign Prim_Valid = ~empty;
    assign Prim_Type  = empty ? 2'd0 : head.ptype;
    assign Prim_V0    = empty ? '0 : head.v0;
    assign Prim_V1    = empty ? '0 : head.v1;
    assign Prim_V2    = empty ? '0 : head.v2;
    assign Stall      = (occ >= CW'(FIFO_DEPTH - 1));
    assign Frame_Done = frame_done;
    assign Err        = err_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_prim_assembler.sv
// Scoreboard bench for prim_assembler: a list-based assembly model feeds an expected queue,
// and a negedge monitor compares every accepted primitive against it.
module tb_prim_assembler;
    localparam int DEPTH = 8;
    localparam int VW    = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [VW-1:0] Vertex;
    logic          VertexValid, StartPrimitive, EndPrimitive, Draw, Prim_Ready;
    logic [3:0]    PrimitiveType;
    logic          Stall, Prim_Valid, Frame_Done, Err, Overflow;
    logic [1:0]    Prim_Type;
    logic [VW-1:0] Prim_V0, Prim_V1, Prim_V2;

    prim_assembler #(.FIFO_DEPTH(DEPTH), .VTX_WIDTH(VW)) dut (
        .CLK(CLK), .RESET(RESET), .Vertex(Vertex), .VertexValid(VertexValid),
        .StartPrimitive(StartPrimitive), .PrimitiveType(PrimitiveType),
        .EndPrimitive(EndPrimitive), .Draw(Draw), .Stall(Stall),
        .Prim_Valid(Prim_Valid), .Prim_Ready(Prim_Ready), .Prim_Type(Prim_Type),
        .Prim_V0(Prim_V0), .Prim_V1(Prim_V1), .Prim_V2(Prim_V2),
        .Frame_Done(Frame_Done), .Err(Err), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]    t;
        logic [VW-1:0] a, b, c;
    } prim_t;

    prim_t         exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            fd_count = 0;

    // reference model state
    bit            m_asm, m_err, m_ovf, m_pend, m_pop;
    int            m_type, m_ntri, m_occ, m_pushed;
    logic [VW-1:0] m_vs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        prim_t e;
        if (!RESET && Prim_Valid && Prim_Ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_prim: got type %0d v0 %0h with nothing expected", Prim_Type, Prim_V0);
            end else begin
                e = exp_q.pop_front();
                chk("prim_type", 64'(Prim_Type), 64'(e.t));
                chk("prim_v0", 64'(Prim_V0), 64'(e.a));
                chk("prim_v1", 64'(Prim_V1), 64'(e.b));
                chk("prim_v2", 64'(Prim_V2), 64'(e.c));
            end
        end
    end

    task automatic model_reset();
        m_asm = 0; m_err = 0; m_ovf = 0; m_pend = 0;
        m_type = 0; m_ntri = 0; m_occ = 0;
        m_vs.delete();
        exp_q.delete();
    endtask

    // A full queue only takes a new primitive if one leaves in the same cycle.
    task automatic emit(input logic [1:0] t, input logic [VW-1:0] a, b, c);
        prim_t p;
        if (m_occ == DEPTH && !m_pop) m_ovf = 1;
        else begin
            p.t = t; p.a = a; p.b = b; p.c = c;
            exp_q.push_back(p);
            m_pushed = 1;
        end
    endtask

    task automatic model_eval();
        bit fd, wind;
        int n;
`ifdef PRIM_STRIP_WINDING_EN
        wind = 1;
`else
        wind = 0;
`endif
        m_pop    = Prim_Ready && m_occ > 0;
        m_pushed = 0;
        fd       = m_pend && !m_asm && m_occ == 0;
        if (StartPrimitive) begin
            if (m_asm) m_err = 1;
            if (PrimitiveType <= 4) begin
                m_asm = 1; m_type = int'(PrimitiveType); m_vs.delete(); m_ntri = 0;
            end else begin
                m_err = 1; m_asm = 0;
            end
        end else if (!m_asm) begin
            if (VertexValid || EndPrimitive) m_err = 1;
        end else begin
            if (VertexValid) begin
                m_vs.push_back(Vertex);
                n = m_vs.size();
                case (m_type)
                    0: begin emit(2'd0, Vertex, '0, '0); m_vs.delete(); end
                    1: if (n == 2) begin emit(2'd1, m_vs[0], m_vs[1], '0); m_vs.delete(); end
                    2: if (n == 3) begin emit(2'd2, m_vs[0], m_vs[1], m_vs[2]); m_vs.delete(); end
                    3: if (n >= 2) begin emit(2'd1, m_vs[n-2], m_vs[n-1], '0); void'(m_vs.pop_front()); end
                    default: if (n >= 3) begin
                        m_ntri++;
                        if (wind && (m_ntri % 2 == 0)) emit(2'd2, m_vs[n-2], m_vs[n-3], m_vs[n-1]);
                        else                           emit(2'd2, m_vs[n-3], m_vs[n-2], m_vs[n-1]);
                        void'(m_vs.pop_front());
                    end
                endcase
            end
            if (EndPrimitive) m_asm = 0;
        end
        m_pend = fd ? 1'b0 : (m_pend | Draw);
        m_occ  = m_occ + m_pushed - int'(m_pop);
    endtask

    // Check the registered-state outputs for this cycle, advance the model, then clock.
    task automatic cycle();
        chk("stall", 64'(Stall), 64'(m_occ >= DEPTH - 1));
        chk("prim_valid", 64'(Prim_Valid), 64'(m_occ > 0));
        chk("err", 64'(Err), 64'(m_err));
        chk("overflow", 64'(Overflow), 64'(m_ovf));
        chk("frame_done", 64'(Frame_Done), 64'(m_pend && !m_asm && m_occ == 0));
        if (Frame_Done) fd_count++;
        model_eval();
        @(posedge CLK); #1;
        VertexValid = 0; StartPrimitive = 0; EndPrimitive = 0; Draw = 0;
    endtask

    task automatic start(input logic [3:0] t);
        StartPrimitive = 1; PrimitiveType = t; cycle();
    endtask

    task automatic vtx(input logic [VW-1:0] v);
        VertexValid = 1; Vertex = v; cycle();
    endtask

    task automatic end_prim();
        EndPrimitive = 1; cycle();
    endtask

    task automatic drain();
        Prim_Ready = 1;
        for (int i = 0; i < 4 * DEPTH && m_occ > 0; i++) cycle();
        cycle();
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_zero();
        chk("rst_stall", 64'(Stall), 64'd0);
        chk("rst_valid", 64'(Prim_Valid), 64'd0);
        chk("rst_type", 64'(Prim_Type), 64'd0);
        chk("rst_v0", 64'(Prim_V0), 64'd0);
        chk("rst_v1", 64'(Prim_V1), 64'd0);
        chk("rst_v2", 64'(Prim_V2), 64'd0);
        chk("rst_frame_done", 64'(Frame_Done), 64'd0);
        chk("rst_err", 64'(Err), 64'd0);
        chk("rst_overflow", 64'(Overflow), 64'd0);
    endtask

    task automatic reset_now();
        VertexValid = 0; StartPrimitive = 0; EndPrimitive = 0; Draw = 0;
        RESET = 1; #2;
        check_zero();
        @(posedge CLK); #1;
        RESET = 0;
        model_reset();
    endtask

    function automatic logic [VW-1:0] vn(input int i);
        return {16'(i), 16'(i)};
    endfunction

    initial begin
        int r;
        RESET = 1; Vertex = '0; VertexValid = 0; StartPrimitive = 0; PrimitiveType = '0;
        EndPrimitive = 0; Draw = 0; Prim_Ready = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_zero();
        RESET = 0;

        // triangles
        Prim_Ready = 1;
        start(4'd2);
        for (int i = 1; i <= 6; i++) vtx(vn(i));
        end_prim();
        drain();

        // line strip
        start(4'd3);
        vtx(32'hA); vtx(32'hB); vtx(32'hC); vtx(32'hD);
        end_prim();
        drain();
        chk("strip_no_err", 64'(Err), 64'd0);

        // backpressure and overflow
        Prim_Ready = 0;
        start(4'd0);
        for (int i = 1; i <= 9; i++) vtx(32'h100 + 32'(i));
        end_prim();
        chk("bp_overflow", 64'(Overflow), 64'd1);
        chk("bp_stall", 64'(Stall), 64'd1);
        drain();

        // triangle strip, 5 vertices
        start(4'd4);
        for (int i = 1; i <= 5; i++) vtx(vn(i));
        end_prim();
        drain();

        // draw with three queued entries
        Prim_Ready = 0;
        start(4'd0);
        vtx(vn(7)); vtx(vn(8)); vtx(vn(9));
        end_prim();
        fd_count = 0;
        Prim_Ready = 1; Draw = 1;
        cycle();
        repeat (8) cycle();
        chk("frame_done_once", 64'(fd_count), 64'd1);

        // errors then mid-assemble reset
        vtx(vn(1));
        chk("idle_vertex_err", 64'(Err), 64'd1);
        start(4'd9);
        vtx(vn(2));
        Prim_Ready = 0;
        start(4'd0);
        vtx(vn(3)); vtx(vn(4));
        start(4'd2);
        vtx(vn(5));
        reset_now();

        // vertex together with StartPrimitive is ignored; vertex with End is processed
        Prim_Ready = 1;
        StartPrimitive = 1; PrimitiveType = 4'd1; VertexValid = 1; Vertex = vn(11); cycle();
        vtx(vn(12));
        VertexValid = 1; Vertex = vn(13); EndPrimitive = 1; cycle();
        drain();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            Prim_Ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 6) begin
                StartPrimitive = 1;
                PrimitiveType = 4'($urandom_range(0, 5));
                VertexValid = $urandom_range(0, 1);
                Vertex = $urandom;
            end else if (r < 11) begin
                EndPrimitive = 1;
            end else if (r < 70) begin
                VertexValid = 1; Vertex = $urandom;
                EndPrimitive = ($urandom_range(0, 19) == 0);
            end else if (r < 73) begin
                Draw = 1;
            end
            cycle();
        end
        end_prim();
        drain();
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
